// File: rtl/serial_sub_pkg.sv
// +--------------------------------------------------------------------+
// | serial_sub_pkg: shared state encoding and sizing for the serial     |
// | ripple-borrow subtractor.                              Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to hold a bit index up to w-1 (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor_cell.sv
// +--------------------------------------------------------------------+
// | full_subtractor_cell: 1-bit combinational a - b - br_in cell.       |
// |                                                        Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
// +--------------------------------------------------------------------+
// | serial_ripple_subtractor: bit-serial Diff = A - B - Bin, LSB first, |
// | valid/ready on both sides. SIGNED_OVF_EN adds the Ovf output.       |
// |                                                        Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_ripple_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SIGNED_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic             d;
  logic             br_next;

  // Operands shift right each cycle, so the current bit is always at [0].
  full_subtractor_cell u_cell (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .br_in  (br),
    .d      (d),
    .br_out (br_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      br        <= 1'b0;
`ifdef SIGNED_OVF_EN
      Ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= A;
            b_sh     <= B;
            br       <= Bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          Diff <= {d, Diff[WIDTH-1:1]};
          if (cnt == LAST) begin
            Bout      <= br_next;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SIGNED_OVF_EN
            // On the last bit a_sh[0]/b_sh[0] are the operand signs and d is the result sign.
            Ovf       <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
